// File: rtl/ram_pkg.sv
// ram_pkg: word geometry and address/merge helpers shared by the RAM top and read pipes
package ram_pkg;
  function automatic int word_bytes(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction
  function automatic logic [63:0] ram_idx(input logic [63:0] addr, input logic [63:0] base,
                                          input int off);
    return (addr - base) >> off;
  endfunction
  // Lower-bound test first so addresses below base never wrap into the array
  function automatic logic ram_in_range(input logic [63:0] addr, input logic [63:0] base,
                                        input logic [63:0] depth, input int off);
    return (addr >= base) && (ram_idx(addr, base, off) < depth);
  endfunction
  function automatic logic [63:0] mask_merge(input logic [63:0] old, input logic [63:0] wdata,
                                             input logic [63:0] wmask);
    return (old & ~wmask) | (wdata & wmask);
  endfunction
endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: LAT-stage {valid, err, data} read pipeline; data stages hold unless valid passes
module ram_rd_pipe #(
  parameter int W = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_err,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_err,
  output logic [W-1:0] out_data
);
  for (genvar s = 0; s < LAT; s++) begin : g_st
    logic v, e, vi, ei;
    logic [W-1:0] d, di;
    if (s == 0) begin : g_in
      assign vi = in_valid;
      assign ei = in_err;
      assign di = in_data;
    end else begin : g_ch
      assign vi = g_st[s-1].v;
      assign ei = g_st[s-1].e;
      assign di = g_st[s-1].d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        e <= 1'b0;
        d <= '0;
      end else begin
        v <= vi;
        e <= vi & ei;
        if (vi) d <= di;
      end
    end
  end
  assign out_valid = g_st[LAT-1].v;
  assign out_err = g_st[LAT-1].e;
  assign out_data = g_st[LAT-1].d;
endmodule

// File: rtl/ram_2r1w_pipe.sv
// ram_2r1w_pipe: fetch read port plus masked data read/write port with pipelined, write-first reads
module ram_2r1w_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH = 65536,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
  parameter int RD_LAT = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_en,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_valid,
  output logic [31:0]       imem_data,
  output logic              imem_err,
  input  logic              dmem_en,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_wmask,
  output logic              dmem_valid,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_err
);
  localparam int WORD_BYTES = word_bytes(DATA_W);
  localparam int OFF_BITS = $clog2(WORD_BYTES);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  if (!(DATA_W == 32 || DATA_W == 64) || RD_LAT < 1 || RD_LAT > 4) begin : g_bad
    $fatal(1, "ram_2r1w_pipe: DATA_W must be 32/64 and RD_LAT 1..4");
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0] i_idx, d_idx;
  logic i_in, d_in, wr, w_err, d_perr;
  logic [DATA_W-1:0] merged, i_word, d_word;
  logic [31:0] i_sel;
  always_comb begin
    i_in = ram_in_range(64'(imem_addr), 64'(BASE_ADDR), 64'(DEPTH), OFF_BITS);
    d_in = ram_in_range(64'(dmem_addr), 64'(BASE_ADDR), 64'(DEPTH), OFF_BITS);
    i_idx = IW'(ram_idx(64'(imem_addr), 64'(BASE_ADDR), OFF_BITS));
    d_idx = IW'(ram_idx(64'(dmem_addr), 64'(BASE_ADDR), OFF_BITS));
    wr = dmem_en & dmem_wen & d_in;
    merged = DATA_W'(mask_merge(64'(mem[d_idx]), 64'(dmem_wdata), 64'(dmem_wmask)));
    i_word = (wr && d_idx == i_idx) ? merged : mem[i_idx];
    d_word = d_in ? mem[d_idx] : '0;
  end
  if (DATA_W == 64) begin : g_sel64
    assign i_sel = imem_addr[2] ? i_word[63:32] : i_word[31:0];
  end else begin : g_sel32
    assign i_sel = i_word[31:0];
  end
  always_ff @(posedge clk) begin
    if (wr) mem[d_idx] <= merged;
  end
  // Dropped writes report their error on the cycle after the write edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_err <= 1'b0;
    else w_err <= dmem_en & dmem_wen & ~d_in;
  end
  ram_rd_pipe #(.W(32), .LAT(RD_LAT)) u_ipipe (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(imem_en),
    .in_err(~i_in),
    .in_data(i_in ? i_sel : 32'h0),
    .out_valid(imem_valid),
    .out_err(imem_err),
    .out_data(imem_data)
  );
  ram_rd_pipe #(.W(DATA_W), .LAT(RD_LAT)) u_dpipe (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(dmem_en & ~dmem_wen),
    .in_err(~d_in),
    .in_data(d_word),
    .out_valid(dmem_valid),
    .out_err(d_perr),
    .out_data(dmem_rdata)
  );
  assign dmem_err = d_perr | w_err;
endmodule

// File: tb/tb_ram_2r1w_pipe.sv
// tb_ram_2r1w_pipe: directed checks of the 2-read/1-write RAM with RD_LAT=3
module tb_ram_2r1w_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_en = 1'b0;
  logic [63:0] imem_addr = '0;
  logic imem_valid, imem_err;
  logic [31:0] imem_data;
  logic dmem_en = 1'b0, dmem_wen = 1'b0;
  logic [63:0] dmem_addr = '0, dmem_wdata = '0, dmem_wmask = '0;
  logic dmem_valid, dmem_err;
  logic [63:0] dmem_rdata;
  int n_vec = 0, n_err = 0, nv = 0, nv0;

  always #5 clk = ~clk;
  always @(negedge clk) if (dmem_valid) nv++;

  ram_2r1w_pipe #(
    .DATA_W(64), .ADDR_W(64), .DEPTH(1024), .BASE_ADDR(64'h8000_0000), .RD_LAT(3), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .imem_err(imem_err),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dwrite(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = a; dmem_wdata = d; dmem_wmask = m;
    cyc();
    dmem_en = 1'b0; dmem_wen = 1'b0;
  endtask

  task automatic dread(input string tag, input logic [63:0] a, input logic [63:0] exp,
                       input logic exp_err);
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_addr = a;
    cyc();
    dmem_en = 1'b0;
    cyc();
    chk({tag, "_early"}, {63'h0, dmem_valid}, 64'h0);
    cyc();
    chk({tag, "_valid"}, {63'h0, dmem_valid}, 64'h1);
    chk({tag, "_data"}, dmem_rdata, exp);
    chk({tag, "_err"}, {63'h0, dmem_err}, {63'h0, exp_err});
  endtask

  task automatic fetch(input string tag, input logic [63:0] a, input logic [31:0] exp,
                       input logic exp_err);
    imem_en = 1'b1; imem_addr = a;
    cyc();
    imem_en = 1'b0;
    cyc();
    cyc();
    chk({tag, "_valid"}, {63'h0, imem_valid}, 64'h1);
    chk({tag, "_data"}, {32'h0, imem_data}, {32'h0, exp});
    chk({tag, "_err"}, {63'h0, imem_err}, {63'h0, exp_err});
  endtask

  initial begin
    imem_en = 1'b1; imem_addr = 64'h8000_0000;
    repeat (4) cyc();
    chk("rst_ivalid", {63'h0, imem_valid}, 64'h0);
    chk("rst_ierr", {63'h0, imem_err}, 64'h0);
    chk("rst_idata", {32'h0, imem_data}, 64'h0);
    chk("rst_dvalid", {63'h0, dmem_valid}, 64'h0);
    chk("rst_derr", {63'h0, dmem_err}, 64'h0);
    chk("rst_drdata", dmem_rdata, 64'h0);
    imem_en = 1'b0;
    rst_n = 1'b1;
    dwrite(64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, '1);
    dwrite(64'h8000_0010, 64'h1122_3344_5566_7788, '1);
    dwrite(64'h8000_0010, 64'h0, 64'h0000_0000_FFFF_0000);
    chk("wr_no_dvalid", {63'h0, dmem_valid}, 64'h0);
    imem_en = 1'b1; imem_addr = 64'h8000_0004;
    cyc();
    imem_en = 1'b0;
    chk("lat_c1", {63'h0, imem_valid}, 64'h0);
    cyc();
    chk("lat_c2", {63'h0, imem_valid}, 64'h0);
    cyc();
    chk("lat_c3_valid", {63'h0, imem_valid}, 64'h1);
    chk("fetch_hi", {32'h0, imem_data}, 64'hAAAA_BBBB);
    cyc();
    chk("lat_pulse", {63'h0, imem_valid}, 64'h0);
    chk("hold_data", {32'h0, imem_data}, 64'hAAAA_BBBB);
    fetch("fetch_lo", 64'h8000_0000, 32'hCCCC_DDDD, 1'b0);
    dread("masked", 64'h8000_0010, 64'h1122_3344_0000_7788, 1'b0);
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 64'h8000_0008; dmem_wdata = 64'h5; dmem_wmask = '1;
    imem_en = 1'b1; imem_addr = 64'h8000_0008;
    cyc();
    dmem_en = 1'b0; dmem_wen = 1'b0; imem_en = 1'b0;
    cyc();
    cyc();
    chk("wfirst_valid", {63'h0, imem_valid}, 64'h1);
    chk("wfirst_data", {32'h0, imem_data}, 64'h5);
    dread("below_base", 64'h7FFF_FFF8, 64'h0, 1'b1);
    dread("full_word", 64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    dread("past_end", 64'h8000_2000, 64'h0, 1'b1);
    dread("wrap_top", 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b1);
    fetch("ifetch_oor", 64'h7FFF_FFFC, 32'h0, 1'b1);
    dwrite(64'h8000_2000, '1, '1);
    chk("oor_wr_err", {63'h0, dmem_err}, 64'h1);
    chk("oor_wr_novalid", {63'h0, dmem_valid}, 64'h0);
    cyc();
    chk("oor_wr_err_pulse", {63'h0, dmem_err}, 64'h0);
    dread("array_kept", 64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    nv0 = nv;
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_addr = 64'h8000_0000;
    cyc();
    dmem_addr = 64'h8000_0008;
    cyc();
    dmem_addr = 64'h8000_0010;
    cyc();
    chk("pipe_v1", {63'h0, dmem_valid}, 64'h1);
    chk("pipe_d1", dmem_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    dmem_addr = 64'h8000_0018;
    cyc();
    chk("pipe_v2", {63'h0, dmem_valid}, 64'h1);
    chk("pipe_d2", dmem_rdata, 64'h5);
    dmem_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("pipe_rst_valid", {63'h0, dmem_valid}, 64'h0);
    chk("pipe_rst_data", dmem_rdata, 64'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("pipe_valid_count", 64'(nv - nv0), 64'd2);
    chk("pipe_after_data", dmem_rdata, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
